lamp_timer_ctrl: RTL and testbench
==================================

LAMP_TIMER_CTRL -- requirements
Module: lamp_timer_ctrl

Interface
REQ-001 Parameter HOLD_CYC, default 255: total lamp-on duration in clk cycles after the last trigger.
REQ-002 Parameter WARN_CYC, default 32: length of the closing warning window, inside HOLD_CYC.
REQ-003 Parameter BLINK_DIV, default 4: cycles per blink half-period during warning.
REQ-004 Parameter CNT_W, default 8: width of the countdown counter.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 S  in  3  three switch levels; asynchronous to clk.
REQ-008 force_on  in  1  manual override; lamp held on while high; synchronous to clk.
REQ-009 F  out  1  lamp drive.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 state  out  2  current FSM state encoding.
REQ-012 remaining  out  CNT_W  current countdown value.

Function
REQ-013 Each S bit SHALL pass a 2-flop synchronizer; p = XOR of the three synchronized bits; p_d = p registered; trig = p XOR p_d.
REQ-014 Any single switch toggle SHALL give one trig pulse, one cycle wide; a toggle captured at edge k SHALL make F high after edge k+2.
REQ-015 FSM states: IDLE=00, ON=01, WARN=10, FORCE=11; F = 1 in ON and FORCE, F = blink in WARN, F = 0 in IDLE.
REQ-016 IDLE -> ON on trig; count SHALL load HOLD_CYC-1.
REQ-017 In ON and WARN, count SHALL decrement by 1 per cycle; ON -> WARN when count = WARN_CYC; WARN -> IDLE when count = 0.
REQ-018 F SHALL be high for exactly HOLD_CYC consecutive cycles per trigger when no further trigger occurs; the last WARN_CYC of those cycles are the WARN window.
REQ-019 blink SHALL start at 0 on WARN entry and toggle every BLINK_DIV cycles.
REQ-020 trig in ON or WARN SHALL reload count to HOLD_CYC-1, enter ON, and reset blink.
REQ-021 force_on high in any state SHALL give FORCE next cycle; count held; trig ignored for FSM, but p_d still tracks p.
REQ-022 force_on falling SHALL give ON with count = HOLD_CYC-1.
REQ-023 Priority when events coincide: force_on > trig > count expiry; trig on the expiry cycle SHALL give ON with a reload, with no IDLE cycle.
REQ-024 Counter arithmetic SHALL be unsigned CNT_W bits and never wrap below 0; legal parameters: WARN_CYC < HOLD_CYC <= 2^CNT_W.

Reset
REQ-025 rst_n low SHALL immediately force: state=IDLE, count=0, blink=0, sync flops=0, p_d=0, F=0, busy=0.
REQ-026 After rst_n release, an armed flag SHALL stay clear for 3 cycles; while clear, p_d tracks p and trig is suppressed, so the switch parity at power-up does not light the lamp.
REQ-027 Reset asserted mid-ON, mid-WARN or mid-FORCE SHALL abort to IDLE with no residual trigger.

Configuration
REQ-028 Macro LAMP_WARN_EN: when defined, WARN state and blink logic SHALL be present as specified.
REQ-029 When LAMP_WARN_EN is undefined: ON -> IDLE directly when count = 0; F is steady high for HOLD_CYC cycles; encoding 10 is unreachable; WARN_CYC and BLINK_DIV are ignored.

Structure
REQ-030 Shared package lamp_pkg SHALL hold the state encodings, the default parameter values, and the state typedef.
REQ-031 Sub-module switch_parity_sync SHALL contain the synchronizers, parity, edge detect and armed logic, and output trig.
REQ-032 The top level SHALL contain only the FSM, counter, blink divider and output decode.

Verification (bench parameters: HOLD_CYC=16, WARN_CYC=4, BLINK_DIV=2, LAMP_WARN_EN defined)
REQ-033 Toggle S[0] once -> F high after edge k+2; F=1 for 12 cycles, then 0,0,1,1 during WARN, then F=0 and busy=0.
REQ-034 Toggle S[1] 10 cycles after the first trig -> remaining reloads to 15, state=ON, total F-high span = 26 cycles.
REQ-035 Hold S=3'b001 through reset release -> no trig, F=0; a later toggle to 3'b011 -> normal 16-cycle sequence.
REQ-036 Assert force_on during WARN for 5 cycles -> state=11, F=1, remaining frozen; on release, state=01 and remaining=15.
REQ-037 Pulse rst_n low mid-ON (remaining=9) -> F=0, state=00 immediately; rerun with LAMP_WARN_EN undefined -> F steady for 16 cycles with no blink.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp timer: state encodings, state type and default parameters.
package lamp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ON    = 2'b01,
        ST_WARN  = 2'b10,
        ST_FORCE = 2'b11
    } lamp_state_t;

    localparam int DEF_HOLD_CYC  = 255;
    localparam int DEF_WARN_CYC  = 32;
    localparam int DEF_BLINK_DIV = 4;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/switch_parity_sync.sv
// Synchronizes three async switches, detects any parity change and emits a one-cycle trig.
// The trig output stays suppressed for three cycles after reset so power-up switch positions are ignored.
module switch_parity_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] s,
    output logic       trig
);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic       p;
    logic       p_d;
    logic [1:0] arm_cnt;
    logic       armed;

    assign p     = ^sync2;
    assign armed = (arm_cnt == 2'd3);
    assign trig  = armed & (p ^ p_d);

    // NOTE: non-blocking assignments let every flop sample its pre-edge input, so
    // sync1 -> sync2 -> p_d form a real pipeline instead of collapsing into one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            p_d     <= 1'b0;
            arm_cnt <= '0;
        end else begin
            sync1 <= s;
            sync2 <= sync1;
            p_d   <= p;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/lamp_timer_ctrl.sv
// Retriggerable lamp timer with manual override and an optional blinking warning window.
// Build option: define LAMP_WARN_EN to include the WARN state and blink behaviour.
module lamp_timer_ctrl
    import lamp_pkg::*;
#(
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int WARN_CYC  = DEF_WARN_CYC,
    parameter int BLINK_DIV = DEF_BLINK_DIV,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       S,
    input  logic             force_on,
    output logic             F,
    output logic             busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] remaining
);

`ifdef LAMP_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    // Count value at which ON is left: into WARN, or straight to IDLE without the warning.
    localparam logic [CNT_W-1:0]   ON_EXIT    = WARN_EN ? CNT_W'(WARN_CYC) : '0;
    localparam int                 BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    lamp_state_t        st;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_dec;
    logic               blink;
    logic [BLINK_W-1:0] blink_cnt;
    logic               trig;

    switch_parity_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (S),
        .trig  (trig)
    );

    // Saturating decrement: the countdown never wraps below zero.
    assign count_dec = (count == '0) ? '0 : count - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ST_IDLE;
            count <= '0;
        end else if (force_on) begin
            st <= ST_FORCE;
        end else if (st == ST_FORCE) begin
            st    <= ST_ON;
            count <= HOLD_LOAD;
        end else if (trig) begin
            st    <= ST_ON;
            count <= HOLD_LOAD;
        end else begin
            case (st)
                ST_ON: begin
                    count <= count_dec;
                    if (count == ON_EXIT) begin
                        if (WARN_EN) st <= ST_WARN;
                        else         st <= ST_IDLE;
                    end
                end
                ST_WARN: begin
                    count <= count_dec;
                    if (count == '0) st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Held at zero outside WARN, so blink always starts low on WARN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (st != ST_WARN) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // NOTE: F gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        F = 1'b0;
        case (st)
            ST_ON, ST_FORCE: F = 1'b1;
            ST_WARN:         F = blink;
            default:         F = 1'b0;
        endcase
    end

    assign state     = st;
    assign busy      = (st != ST_IDLE);
    assign remaining = count;

endmodule

// File: tb/tb_lamp_timer_ctrl.sv
// Directed bench for lamp_timer_ctrl (HOLD_CYC=16, WARN_CYC=4, BLINK_DIV=2); follows LAMP_WARN_EN of the build.
module tb_lamp_timer_ctrl;

    localparam int HOLD  = 16;
    localparam int WARN  = 4;
    localparam int BLINK = 2;
    localparam int CW    = 8;

`ifdef LAMP_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ON    = 2'b01;
    localparam logic [1:0] S_WARN  = 2'b10;
    localparam logic [1:0] S_FORCE = 2'b11;
    localparam int         NROWS   = 20;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic [2:0]    S        = 3'b000;
    logic          force_on = 1'b0;
    logic          F;
    logic          busy;
    logic [1:0]    state;
    logic [CW-1:0] remaining;

    lamp_timer_ctrl #(
        .HOLD_CYC  (HOLD),
        .WARN_CYC  (WARN),
        .BLINK_DIV (BLINK),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .S         (S),
        .force_on  (force_on),
        .F         (F),
        .busy      (busy),
        .state     (state),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    s;
        logic          force_on;
        logic [1:0]    exp_state;
        logic          exp_f;
        logic [CW-1:0] exp_rem;
    } vec_t;

    vec_t tbl [NROWS];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] pack(logic [1:0] st, logic f, logic b, logic [CW-1:0] r);
        return {4'b0000, st, f, b, r};
    endfunction

    function automatic logic [15:0] obs();
        return pack(state, F, busy, remaining);
    endfunction

    // Expected trace for one isolated trigger: two quiet cycles, 16 lit cycles, then IDLE.
    task automatic build_table(input logic [2:0] s_new);
        logic [3:0] warn_f;
        int         rem;
        warn_f = 4'b0011;
        for (int r = 0; r < NROWS; r++) begin
            tbl[r].s        = s_new;
            tbl[r].force_on = 1'b0;
            if (r < 2 || r >= 2 + HOLD) begin
                tbl[r].exp_state = S_IDLE;
                tbl[r].exp_f     = 1'b0;
                tbl[r].exp_rem   = '0;
            end else begin
                rem            = HOLD - 1 - (r - 2);
                tbl[r].exp_rem = CW'(rem);
                if (WARN_EN && rem < WARN) begin
                    tbl[r].exp_state = S_WARN;
                    tbl[r].exp_f     = warn_f[rem];
                end else begin
                    tbl[r].exp_state = S_ON;
                    tbl[r].exp_f     = 1'b1;
                end
            end
        end
    endtask

    task automatic run_table(input string name);
        for (int r = 0; r < NROWS; r++) begin
            S        = tbl[r].s;
            force_on = tbl[r].force_on;
            @(negedge clk);
            check($sformatf("%s[%0d]", name, r), obs(),
                  pack(tbl[r].exp_state, tbl[r].exp_f, tbl[r].exp_state != S_IDLE, tbl[r].exp_rem));
        end
    endtask

    initial begin
        int first;
        int last;
        int busy_n;
        int highs;
        logic [1:0] exp_st;

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", obs(), pack(S_IDLE, 1'b0, 1'b0, '0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", obs(), pack(S_IDLE, 1'b0, 1'b0, '0));

        // Single toggle of S[0]: full hold and warning sequence
        build_table(3'b001);
        run_table("single");

        // Retrigger with S[1] ten cycles after the first trigger
        S      = 3'b000;
        first  = -1;
        last   = -1;
        busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (F) begin
                if (first < 0) first = c;
                last = c;
            end
            if (busy) busy_n++;
            if (c == 11) check("retrig_before", obs(), pack(S_ON, 1'b1, 1'b1, 8'd6));
            if (c == 12) check("retrig_reload", obs(), pack(S_ON, 1'b1, 1'b1, 8'd15));
            if (c == 9) S = 3'b010;
        end
        check("retrig_first_high", 16'(first), 16'd2);
        check("retrig_span", 16'(last - first + 1), 16'd26);
        check("retrig_busy_cycles", 16'(busy_n), 16'd26);

        // Switch parity held through reset release must not light the lamp
        rst_n = 1'b0;
        S     = 3'b001;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        highs  = 0;
        busy_n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (F) highs++;
            if (busy) busy_n++;
        end
        check("pwrup_no_lamp", 16'(highs), 16'd0);
        check("pwrup_no_busy", 16'(busy_n), 16'd0);
        build_table(3'b011);
        run_table("pwrup_toggle");

        // force_on for five cycles starting inside the warning window
        S = 3'b111;
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            if (c >= 15 && c <= 19)
                check($sformatf("force_hold[%0d]", c), obs(), pack(S_FORCE, 1'b1, 1'b1, 8'd3));
            if (c == 20) check("force_release", obs(), pack(S_ON, 1'b1, 1'b1, 8'd15));
            if (c == 36) check("force_expire", obs(), pack(S_IDLE, 1'b0, 1'b0, '0));
            if (c == 14) force_on = 1'b1;
            if (c == 19) force_on = 1'b0;
        end

        // Trigger landing on the expiry cycle reloads without an IDLE cycle
        S      = 3'b110;
        exp_st = WARN_EN ? S_WARN : S_ON;
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            if (c == 17) check("expiry_last_cycle", obs(), pack(exp_st, 1'b1, 1'b1, '0));
            if (c == 18) check("expiry_retrig", obs(), pack(S_ON, 1'b1, 1'b1, 8'd15));
            if (c == 34) check("expiry_final_idle", obs(), pack(S_IDLE, 1'b0, 1'b0, '0));
            if (c == 15) S = 3'b100;
        end

        // Asynchronous reset in the middle of ON
        S = 3'b101;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 8) check("mid_on_before_reset", obs(), pack(S_ON, 1'b1, 1'b1, 8'd9));
        end
        #1 rst_n = 1'b0;
        #1 check("mid_on_async_reset", obs(), pack(S_IDLE, 1'b0, 1'b0, '0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (F || busy) highs++;
        end
        check("no_residual_trigger", 16'(highs), 16'd0);
        check("final_idle", obs(), pack(S_IDLE, 1'b0, 1'b0, '0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
